// File: rtl/ddr_wr_burst_mch.sv
// Multi-channel DDR write burst scheduler: round-robin arbitration over per-channel FWFT FIFOs,
// each channel writing into its own ring region of BLK_SIZE blocks.
module ddr_wr_burst_mch #(
    parameter int unsigned CH_NUM      = 4,
    parameter int unsigned WR_DATA_WD  = 128,
    parameter int unsigned DDR_ADDR_WD = 32,
    parameter int unsigned DDR_DATA_WD = 512,
    parameter int unsigned CNT_WD      = 12,
    parameter int unsigned BURST_LEN   = 16,
    parameter int unsigned BLK_SIZE    = 32'h1000,
    parameter int unsigned BASE_ADDR   = 32'h0,
    localparam int unsigned CH_W       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                            ddr_clk,
    input  logic                            ddr_rst,
    input  logic                            cfg_rst,
    input  logic [CH_NUM-1:0]               ch_flush,
    input  logic [CH_NUM*CNT_WD-1:0]        ch_rd_cnt,
    input  logic [CH_NUM-1:0]               ch_empty,
    input  logic [CH_NUM*DDR_DATA_WD-1:0]   ch_dout,
    output logic [CH_NUM-1:0]               ch_rd,
    output logic                            wr_burst_req,
    output logic [9:0]                      wr_burst_len,
    output logic [DDR_ADDR_WD-1:0]          wr_burst_addr,
    input  logic                            wr_burst_data_req,
    output logic [DDR_DATA_WD-1:0]          wr_burst_data,
    input  logic                            wr_burst_finish,
    output logic [CH_W-1:0]                 cur_ch,
    output logic                            busy,
    output logic [CH_NUM*DDR_ADDR_WD-1:0]   wr_glb_blk_cnt,
    output logic                            ovr_err
);

    localparam int unsigned RATE = DDR_DATA_WD / WR_DATA_WD;

    typedef logic [DDR_ADDR_WD-1:0] addr_t;
    typedef enum logic [2:0] {S_IDLE, S_ARB, S_REQ, S_DATA, S_UPD} state_e;

    state_e              state_q, state_d;
    addr_t               glb_q [CH_NUM];
    addr_t               glb_d [CH_NUM];
    logic [CH_NUM-1:0]   flush_pend_q, flush_pend_d, pend_clr;
    logic                ovr_q, ovr_d;
    logic [CH_W-1:0]     cur_ch_q, cur_ch_d;
    logic [CH_W-1:0]     last_gnt_q, last_gnt_d;
    addr_t               beat_q, beat_d;
    addr_t               len_q, len_d;
    addr_t               addr_q, addr_d;
    logic                partial_q, partial_d;

    logic [CNT_WD-1:0]   rd_cnt [CH_NUM];
    logic [CH_NUM-1:0]   full_elig, elig;
    logic [CH_W-1:0]     gnt;
    addr_t               arb_off, arb_base, arb_room, arb_len, arb_addr;
    logic [DDR_DATA_WD-1:0] sel_dout;

    always_comb begin
        for (int c = 0; c < int'(CH_NUM); c++) begin
            rd_cnt[c]    = ch_rd_cnt[c*CNT_WD +: CNT_WD];
            full_elig[c] = !ch_empty[c] && (rd_cnt[c] >= CNT_WD'(BURST_LEN));
            elig[c]      = full_elig[c] || (flush_pend_q[c] && (rd_cnt[c] != '0));
        end
    end

    // Round-robin search starting one past the previous grant.
    always_comb begin
        logic found;
        found = 1'b0;
        gnt   = last_gnt_q;
        for (int i = 1; i <= int'(CH_NUM); i++) begin
            int idx;
            idx = (int'(last_gnt_q) + i) % int'(CH_NUM);
            if (!found && elig[idx]) begin
                found = 1'b1;
                gnt   = CH_W'(idx);
            end
        end
    end

    // Clip so a burst never runs past the end of the channel's ring region.
    always_comb begin
        arb_off  = glb_q[gnt] & addr_t'(BLK_SIZE - 1);
        arb_base = full_elig[gnt] ? addr_t'(BURST_LEN) : addr_t'(rd_cnt[gnt]);
        arb_room = addr_t'(BLK_SIZE) - arb_off;
        arb_len  = (arb_base < arb_room) ? arb_base : arb_room;
        arb_addr = addr_t'(BASE_ADDR) + ((addr_t'(gnt) * addr_t'(BLK_SIZE) + arb_off) << 3);
    end

    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        state_d    = state_q;
        glb_d      = glb_q;
        ovr_d      = ovr_q;
        cur_ch_d   = cur_ch_q;
        last_gnt_d = last_gnt_q;
        beat_d     = beat_q;
        len_d      = len_q;
        addr_d     = addr_q;
        partial_d  = partial_q;
        pend_clr   = '0;
        ch_rd      = '0;
        unique case (state_q)
            S_IDLE: if (|elig) state_d = S_ARB;
            S_ARB: begin
                cur_ch_d   = gnt;
                last_gnt_d = gnt;
                len_d      = arb_len;
                addr_d     = arb_addr;
                partial_d  = !full_elig[gnt];
                beat_d     = '0;
                for (int c = 0; c < int'(CH_NUM); c++)
                    if (rd_cnt[c] == '0) pend_clr[c] = 1'b1;
                state_d    = S_REQ;
            end
            S_REQ, S_DATA: begin
                if (wr_burst_data_req) begin
                    if (beat_q < len_q) begin
                        ch_rd[cur_ch_q] = 1'b1;
                        beat_d          = beat_q + 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
                if (wr_burst_finish)
                    state_d = S_UPD;
                else if (state_q == S_REQ && wr_burst_data_req)
                    state_d = S_DATA;
            end
            S_UPD: begin
                glb_d[cur_ch_q] = glb_q[cur_ch_q] + len_q;
                if (partial_q) pend_clr[cur_ch_q] = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A new flush request outranks a clear in the same cycle.
        flush_pend_d = (flush_pend_q & ~pend_clr) | ch_flush;
    end

    always_ff @(posedge ddr_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (ddr_rst || cfg_rst) begin
            state_q      <= S_IDLE;
            for (int c = 0; c < int'(CH_NUM); c++) glb_q[c] <= '0;
            flush_pend_q <= '0;
            ovr_q        <= 1'b0;
            cur_ch_q     <= '0;
            last_gnt_q   <= CH_W'(CH_NUM - 1);
            beat_q       <= '0;
            len_q        <= '0;
            addr_q       <= '0;
            partial_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            glb_q        <= glb_d;
            flush_pend_q <= flush_pend_d;
            ovr_q        <= ovr_d;
            cur_ch_q     <= cur_ch_d;
            last_gnt_q   <= last_gnt_d;
            beat_q       <= beat_d;
            len_q        <= len_d;
            addr_q       <= addr_d;
            partial_q    <= partial_d;
        end
    end

    always_comb begin
        sel_dout = ch_dout[cur_ch_q*DDR_DATA_WD +: DDR_DATA_WD];
        for (int i = 0; i < int'(RATE); i++)
            wr_burst_data[i*WR_DATA_WD +: WR_DATA_WD] = sel_dout[(int'(RATE)-1-i)*WR_DATA_WD +: WR_DATA_WD];
    end

    always_comb begin
        for (int c = 0; c < int'(CH_NUM); c++)
            wr_glb_blk_cnt[c*DDR_ADDR_WD +: DDR_ADDR_WD] = glb_q[c];
    end

    assign wr_burst_req  = (state_q == S_REQ);
    assign wr_burst_len  = 10'(len_q);
    assign wr_burst_addr = addr_q;
    assign cur_ch        = cur_ch_q;
    assign busy          = (state_q != S_IDLE);
    assign ovr_err       = ovr_q;

endmodule

// File: tb/tb_ddr_wr_burst_mch.sv
// Self-checking bench for ddr_wr_burst_mch: directed scenarios plus randomized rounds
// checked against an arithmetic model of grants, lengths, addresses and counters.
module tb_ddr_wr_burst_mch;

    localparam int CH = 4;
    localparam int DW = 512;
    localparam int LW = 128;
    localparam int AW = 32;
    localparam int CW = 12;
    localparam int BL = 16;
    localparam int BS = 4096;

    logic              ddr_clk = 1'b0;
    logic              ddr_rst, cfg_rst;
    logic [CH-1:0]     ch_flush, ch_empty, ch_rd;
    logic [CH*CW-1:0]  ch_rd_cnt;
    logic [CH*DW-1:0]  ch_dout;
    logic              wr_burst_req, wr_burst_data_req, wr_burst_finish, busy, ovr_err;
    logic [9:0]        wr_burst_len;
    logic [AW-1:0]     wr_burst_addr;
    logic [DW-1:0]     wr_burst_data;
    logic [1:0]        cur_ch;
    logic [CH*AW-1:0]  wr_glb_blk_cnt;

    ddr_wr_burst_mch dut (
        .ddr_clk(ddr_clk), .ddr_rst(ddr_rst), .cfg_rst(cfg_rst),
        .ch_flush(ch_flush), .ch_rd_cnt(ch_rd_cnt), .ch_empty(ch_empty), .ch_dout(ch_dout),
        .ch_rd(ch_rd), .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len),
        .wr_burst_addr(wr_burst_addr), .wr_burst_data_req(wr_burst_data_req),
        .wr_burst_data(wr_burst_data), .wr_burst_finish(wr_burst_finish),
        .cur_ch(cur_ch), .busy(busy), .wr_glb_blk_cnt(wr_glb_blk_cnt), .ovr_err(ovr_err)
    );

    always #5 ddr_clk = ~ddr_clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state.
    int          m_cnt  [CH];
    bit          m_pend [CH];
    int unsigned m_glb  [CH];
    int          m_last;
    bit          m_ovr;

    int obs_ch;
    int obs_addr;
    int obs_len;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] lane_rev(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        for (int i = 0; i < DW/LW; i++) r[i*LW +: LW] = d[(DW/LW-1-i)*LW +: LW];
        return r;
    endfunction

    function automatic bit m_elig(input int c);
        return (m_cnt[c] >= BL) || (m_pend[c] && m_cnt[c] > 0);
    endfunction

    function automatic bit m_any_elig();
        bit a = 0;
        for (int c = 0; c < CH; c++) a |= m_elig(c);
        return a;
    endfunction

    function automatic logic [CH*AW-1:0] m_glb_flat();
        logic [CH*AW-1:0] f;
        for (int c = 0; c < CH; c++) f[c*AW +: AW] = m_glb[c];
        return f;
    endfunction

    task automatic drive_cnts();
        for (int c = 0; c < CH; c++) begin
            ch_rd_cnt[c*CW +: CW] = CW'(m_cnt[c]);
            ch_empty[c]           = (m_cnt[c] == 0);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_glb[c]  = 0;
            m_pend[c] = 0;
        end
        m_last = CH - 1;
        m_ovr  = 0;
    endtask

    task automatic pulse_cfg_rst();
        cfg_rst = 1'b1;
        @(negedge ddr_clk);
        cfg_rst = 1'b0;
        model_reset();
    endtask

    task automatic pulse_flush(input logic [CH-1:0] bits);
        ch_flush = bits;
        for (int c = 0; c < CH; c++) if (bits[c]) m_pend[c] = 1;
        @(negedge ddr_clk);
        ch_flush = '0;
    endtask

    // Acts as the DDR controller for one burst; `extra` data requests beyond the length overrun it.
    task automatic do_burst(input int extra);
        int c, off, base, len, got;
        bit part;
        logic [CH-1:0] exp_rd;
        c = 0;
        for (int i = CH; i >= 1; i--)
            if (m_elig((m_last + i) % CH)) c = (m_last + i) % CH;
        got = 0;
        for (int t = 0; t < 40 && got == 0; t++) begin
            @(negedge ddr_clk);
            if (wr_burst_req === 1'b1) got = 1;
        end
        check("req_seen", got, 1);
        if (got == 0) return;
        for (int k = 0; k < CH; k++) if (m_cnt[k] == 0) m_pend[k] = 0;
        part = !(m_cnt[c] >= BL);
        base = part ? m_cnt[c] : BL;
        off  = int'(m_glb[c] % BS);
        len  = (base < BS - off) ? base : BS - off;
        obs_ch   = int'(cur_ch);
        obs_addr = int'(wr_burst_addr);
        obs_len  = int'(wr_burst_len);
        check("grant", cur_ch, c);
        check("len", wr_burst_len, len & 10'h3FF);
        check("addr", wr_burst_addr, (c * BS + off) * 8);
        check("req_only_in_req", busy, 1);
        for (int k = 0; k < len + extra; k++) begin
            wr_burst_data_req = 1'b1;
            #1;
            exp_rd = (k < len) ? CH'(1 << c) : '0;
            check("ch_rd", ch_rd, exp_rd);
            if (k == 0) check("data_lanes", wr_burst_data, lane_rev(ch_dout[c*DW +: DW]));
            if (k < len) begin
                m_cnt[c]--;
                drive_cnts();
            end
            @(negedge ddr_clk);
            if (k == 0) check("req_drops", wr_burst_req, 0);
        end
        wr_burst_data_req = 1'b0;
        wr_burst_finish   = 1'b1;
        @(negedge ddr_clk);
        wr_burst_finish   = 1'b0;
        @(negedge ddr_clk);
        check("idle_after_upd", busy, 0);
        m_glb[c] += len;
        if (part) m_pend[c] = 0;
        if (extra > 0) m_ovr = 1;
        m_last = c;
        check("glb_cnt", wr_glb_blk_cnt, m_glb_flat());
        check("ovr_err", ovr_err, m_ovr);
    endtask

    initial begin
        int order[5];
        int got;
        ddr_rst = 1'b1; cfg_rst = 1'b0; ch_flush = '0;
        wr_burst_data_req = 1'b0; wr_burst_finish = 1'b0;
        for (int c = 0; c < CH; c++) m_cnt[c] = 0;
        drive_cnts();
        for (int w = 0; w < CH*DW/32; w++) ch_dout[w*32 +: 32] = $urandom;
        model_reset();
        repeat (2) @(negedge ddr_clk);
        ddr_rst = 1'b0;

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_req", wr_burst_req, 0);
        check("rst_ch_rd", ch_rd, 0);
        check("rst_ovr", ovr_err, 0);
        check("rst_cur_ch", cur_ch, 0);
        check("rst_glb", wr_glb_blk_cnt, 0);

        // Single channel, then the follow-on burst address
        m_cnt[0] = 16; drive_cnts();
        do_burst(0);
        check("single_addr", obs_addr, 0);
        check("single_len", obs_len, 16);
        check("single_glb0", wr_glb_blk_cnt[AW-1:0], 16);
        m_cnt[0] = 16; drive_cnts();
        do_burst(0);
        check("single_next_addr", obs_addr, 32'h80);

        // Round robin from a fresh clear
        pulse_cfg_rst();
        for (int c = 0; c < CH; c++) m_cnt[c] = 32;
        drive_cnts();
        for (int b = 0; b < 5; b++) begin
            do_burst(0);
            order[b] = obs_ch;
            if (b == 2) check("rr_ch2_addr", obs_addr, 32'h10000);
        end
        check("rr_order", {order[0][3:0], order[1][3:0], order[2][3:0], order[3][3:0], order[4][3:0]}, 20'h01230);
        while (m_any_elig()) do_burst(0);

        // Flush of a partial FIFO; flush_pend must not survive the burst
        pulse_cfg_rst();
        m_cnt[1] = 5; drive_cnts();
        pulse_flush(4'b0010);
        do_burst(0);
        check("flush_len", obs_len, 5);
        check("flush_glb1", wr_glb_blk_cnt[AW +: AW], 5);
        m_cnt[1] = 3; drive_cnts();
        repeat (10) @(negedge ddr_clk);
        check("flush_pend_cleared", busy, 0);
        m_cnt[1] = 0; drive_cnts();

        // Ring wrap with clipping at offset 4091
        pulse_cfg_rst();
        m_cnt[0] = 4080; drive_cnts();
        while (m_elig(0)) do_burst(0);
        m_cnt[0] = 11; drive_cnts();
        pulse_flush(4'b0001);
        do_burst(0);
        check("wrap_pre_cnt", wr_glb_blk_cnt[AW-1:0], 32'hFFB);
        m_cnt[0] = 16; drive_cnts();
        do_burst(0);
        check("wrap_clip_len", obs_len, 5);
        check("wrap_clip_addr", obs_addr, 4091 * 8);
        m_cnt[0] = 16; drive_cnts();
        do_burst(0);
        check("wrap_restart_addr", obs_addr, 0);
        m_cnt[0] = 0; drive_cnts();

        // Overrun: 17 data requests on a 16-beat burst
        pulse_cfg_rst();
        m_cnt[0] = 16; drive_cnts();
        do_burst(1);
        repeat (5) @(negedge ddr_clk);
        check("ovr_sticky", ovr_err, 1);
        pulse_cfg_rst();
        check("ovr_cleared", ovr_err, 0);

        // ddr_rst in the middle of a burst
        m_cnt[0] = 16; drive_cnts();
        got = 0;
        for (int t = 0; t < 40 && got == 0; t++) begin
            @(negedge ddr_clk);
            if (wr_burst_req === 1'b1) got = 1;
        end
        check("mid_req_seen", got, 1);
        wr_burst_data_req = 1'b1;
        repeat (8) @(negedge ddr_clk);
        wr_burst_data_req = 1'b0;
        ddr_rst = 1'b1;
        @(negedge ddr_clk);
        ddr_rst = 1'b0;
        model_reset();
        check("mid_busy", busy, 0);
        check("mid_req", wr_burst_req, 0);
        check("mid_ch_rd", ch_rd, 0);
        check("mid_glb", wr_glb_blk_cnt, 0);
        check("mid_cur_ch", cur_ch, 0);
        m_cnt[0] = 0; drive_cnts();
        @(negedge ddr_clk);

        // Randomized rounds against the model
        for (int r = 0; r < 30; r++) begin
            int guard = 0;
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 1) == 1) m_cnt[c] = m_cnt[c] + int'($urandom_range(0, 40));
            drive_cnts();
            pulse_flush(CH'($urandom_range(0, 15)));
            while (m_any_elig() && guard < 40) begin
                do_burst(($urandom_range(0, 9) == 0) ? 1 : 0);
                guard++;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
